// File: rtl/m8b_32b_arb.sv
// m8b_32b_arb: word-granular round-robin arbiter feeding the m8b_32b byte input.
// Ports: clk_4f/reset_L; req/valid_in/data_in from 4 byte sources;
// data_out/valid_out/word_first/word_last/abort to m8b_32b; grant one-hot back to sources.
module m8b_32b_arb #(
    parameter int         N_REQ    = 4,
    parameter int         TIMEOUT  = 8,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic               clk_4f,
    input  logic               reset_L,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   valid_in,
    input  logic [8*N_REQ-1:0] data_in,
    output logic [7:0]         data_out,
    output logic               valid_out,
    output logic [N_REQ-1:0]   grant,
    output logic               word_first,
    output logic               word_last,
    output logic               abort
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        PAD
    } state_t;

    state_t     state;
    logic [1:0] g;
    logic [1:0] byte_cnt;
    logic [7:0] idle_cnt;
    logic [1:0] rr_ptr;

    logic [1:0] nxt;
    logic [1:0] arb_from;
    logic [2:0] pick_res;
    logic [7:0] sel_byte;
    logic       timed_out;
    logic       take;
    logic       pad_go;
    logic       drop;
    logic       emit;
    logic       done;

    // Returns {found, index} of the first set request at or after 'from',
    // wrapping 3 -> 0. Scanning k downward lets the nearest hit win.
    function automatic logic [2:0] pick(input logic [3:0] r,
                                        input logic [1:0] from);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = from + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        nxt       = g + 2'd1;
        // Word completion re-arbitrates from the slot after the owner.
        arb_from  = (state == IDLE) ? rr_ptr : nxt;
        pick_res  = pick(req, arb_from);
        sel_byte  = data_in[{g, 3'b000} +: 8];
        timed_out = (idle_cnt >= 8'(TIMEOUT));
        take      = (state == XFER) && valid_in[g];
        // A late byte beats the timeout: only a still-idle cycle pads.
        pad_go    = (state == XFER) && !valid_in[g] && timed_out
                    && (byte_cnt != 2'd0);
        drop      = (state == XFER) && !valid_in[g] && timed_out
                    && (byte_cnt == 2'd0);
        emit      = take || pad_go || (state == PAD);
        done      = emit && (byte_cnt == 2'd3);
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state      <= IDLE;
            g          <= 2'd0;
            byte_cnt   <= 2'd0;
            idle_cnt   <= 8'd0;
            rr_ptr     <= 2'd0;
            data_out   <= 8'd0;
            valid_out  <= 1'b0;
            grant      <= '0;
            word_first <= 1'b0;
            word_last  <= 1'b0;
            abort      <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            word_first <= 1'b0;
            word_last  <= 1'b0;
            abort      <= 1'b0;
            if (emit) begin
                data_out   <= take ? sel_byte : PAD_BYTE;
                valid_out  <= 1'b1;
                word_first <= (byte_cnt == 2'd0);
                word_last  <= (byte_cnt == 2'd3);
                abort      <= pad_go;
                idle_cnt   <= 8'd0;
                // 2-bit counter wraps to 0 exactly on the 4th byte.
                byte_cnt   <= byte_cnt + 2'd1;
                if (done) begin
                    rr_ptr <= nxt;
                    if (pick_res[2]) begin
                        g     <= pick_res[1:0];
                        grant <= 4'b0001 << pick_res[1:0];
                        state <= XFER;
                    end else begin
                        grant <= '0;
                        state <= IDLE;
                    end
                end else if (!take) begin
                    grant <= '0;
                    state <= PAD;
                end
            end else if (drop) begin
                grant  <= '0;
                rr_ptr <= nxt;
                state  <= IDLE;
            end else if (state == IDLE) begin
                grant <= '0;
                if (pick_res[2]) begin
                    g        <= pick_res[1:0];
                    grant    <= 4'b0001 << pick_res[1:0];
                    byte_cnt <= 2'd0;
                    idle_cnt <= 8'd0;
                    state    <= XFER;
                end
            end else if (idle_cnt != 8'hFF) begin
                idle_cnt <= idle_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_m8b_32b_arb.sv
// tb_m8b_32b_arb: directed and randomized checks of m8b_32b_arb
// against a word-level reference model of the arbitration rules.
module tb_m8b_32b_arb;

    localparam int         TO   = 8;
    localparam logic [7:0] PADB = 8'h00;

    logic        clk_4f = 1'b0;
    logic        reset_L;
    logic [3:0]  req;
    logic [3:0]  valid_in;
    logic [31:0] data_in;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [3:0]  grant;
    logic        word_first;
    logic        word_last;
    logic        abort;

    always #5 clk_4f = ~clk_4f;

    m8b_32b_arb dut (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .req       (req),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .grant     (grant),
        .word_first(word_first),
        .word_last (word_last),
        .abort     (abort)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state: owner index (-1 = nobody), bytes in word,
    // idle cycles, pointer to next search start, padding flag
    int   own, nb, quiet, ptr, took;
    bit   padding;
    logic [7:0] e_data;
    logic [3:0] e_grant;
    logic e_valid, e_first, e_last, e_abort;

    logic [7:0] base [4];
    int         seq  [4];
    bit         rnd;

    logic [7:0] obs_bytes[$];
    logic [3:0] obs_wg[$];
    bit         obs_first[$];
    bit         obs_last[$];
    int         since_last;
    int         n_abort;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int from);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (from + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        own = -1; nb = 0; quiet = 0; ptr = 0; took = -1;
        padding = 0;
        e_data = 8'd0; e_grant = 4'd0;
        e_valid = 0; e_first = 0; e_last = 0; e_abort = 0;
    endtask

    task automatic model_step();
        int w;
        logic [7:0] b;
        bit emit;
        took = -1; emit = 0; b = PADB;
        e_valid = 0; e_first = 0; e_last = 0; e_abort = 0;
        if (padding) begin
            emit = 1;
        end else if (own < 0) begin
            w = pick(req, ptr);
            e_grant = 4'd0;
            if (w >= 0) begin
                own = w; nb = 0; quiet = 0;
                e_grant = 4'(1 << w);
            end
        end else if (valid_in[own]) begin
            emit = 1; b = data_in[8*own +: 8]; quiet = 0; took = own;
        end else if (quiet >= TO) begin
            if (nb > 0) begin
                padding = 1; emit = 1; e_abort = 1;
            end else begin
                ptr = (own + 1) % 4; own = -1; e_grant = 4'd0;
            end
        end else if (quiet < 255) begin
            quiet++;
        end
        if (emit) begin
            e_valid = 1; e_data = b;
            e_first = (nb == 0); e_last = (nb == 3);
            nb++;
            if (padding) e_grant = 4'd0;
            if (nb == 4) begin
                ptr = (own + 1) % 4; padding = 0; nb = 0;
                w = pick(req, ptr);
                if (w >= 0) begin
                    own = w; quiet = 0; e_grant = 4'(1 << w);
                end else begin
                    own = -1; e_grant = 4'd0;
                end
            end
        end
    endtask

    task automatic drive();
        if (!rnd)
            for (int i = 0; i < 4; i++)
                data_in[8*i +: 8] = base[i] + 8'(seq[i]);
    endtask

    task automatic tick();
        @(posedge clk_4f);
        if (reset_L) model_step();
        else model_reset();
        #1;
        chk("valid_out", 32'(valid_out), 32'(e_valid));
        chk("grant", 32'(grant), 32'(e_grant));
        chk("word_first", 32'(word_first), 32'(e_first));
        chk("word_last", 32'(word_last), 32'(e_last));
        chk("abort", 32'(abort), 32'(e_abort));
        if (e_valid) chk("data_out", 32'(data_out), 32'(e_data));
        if (valid_out) begin
            obs_bytes.push_back(data_out);
            obs_first.push_back(word_first);
            obs_last.push_back(word_last);
            since_last++;
            if (word_first) obs_wg.push_back(grant);
            if (word_last) begin
                chk("word_len", 32'(since_last), 32'd4);
                since_last = 0;
            end
        end
        if (abort) n_abort++;
        if (took >= 0) seq[took]++;
        drive();
    endtask

    task automatic clear_obs();
        obs_bytes.delete(); obs_wg.delete();
        obs_first.delete(); obs_last.delete();
        since_last = 0; n_abort = 0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
    endtask

    task automatic do_reset();
        req = 4'd0; valid_in = 4'd0;
        reset_L = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
        clear_obs();
        drive();
    endtask

    initial begin
        reset_L = 1'b1; req = 4'd0; valid_in = 4'd0; data_in = 32'd0;
        rnd = 0;
        for (int i = 0; i < 4; i++) base[i] = 8'd0;
        model_reset();
        clear_obs();
        #2;
        do_reset();

        // 1: reset mid-word, then a fresh word
        base[0] = 8'hA0; drive();
        req = 4'b0001; valid_in = 4'b0001;
        tick(); tick(); tick();
        reset_L = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_first", 32'(word_first), 32'd0);
        chk("rst_last", 32'(word_last), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        model_reset();
        since_last = 0;
        tick(); tick();
        reset_L = 1'b1;
        clear_obs(); drive();
        for (int k = 0; k < 6; k++) tick();
        chk("t1_first", 32'(obs_first[0]), 32'd1);
        chk("t1_byte0", 32'(obs_bytes[0]), 32'hA0);
        chk("t1_last", 32'(obs_last[3]), 32'd1);

        // 2: lone requester, back-to-back regrant
        do_reset();
        base[0] = 8'hA0; drive();
        req = 4'b0001; valid_in = 4'b0001;
        for (int k = 0; k < 6; k++) tick();
        for (int k = 0; k < 5; k++)
            chk("t2_byte", 32'(obs_bytes[k]), 32'(8'hA0 + 8'(k)));
        chk("t2_nbytes", 32'(obs_bytes.size()), 32'd5);

        // 3: all four streaming
        do_reset();
        for (int i = 0; i < 4; i++) base[i] = 8'(i * 16);
        drive();
        req = 4'b1111; valid_in = 4'b1111;
        for (int k = 0; k < 21; k++) tick();
        for (int k = 0; k < 16; k++)
            chk("t3_byte", 32'(obs_bytes[k]), 32'((k / 4) * 16 + k % 4));
        chk("t3_g0", 32'(obs_wg[0]), 32'h1);
        chk("t3_g1", 32'(obs_wg[1]), 32'h2);
        chk("t3_g2", 32'(obs_wg[2]), 32'h4);
        chk("t3_g3", 32'(obs_wg[3]), 32'h8);
        chk("t3_g4", 32'(obs_wg[4]), 32'h1);

        // 4: stall after two bytes -> pad abort
        do_reset();
        base[1] = 8'h10; drive();
        req = 4'b0010; valid_in = 4'b0010;
        tick(); tick(); tick();
        valid_in = 4'b0000;
        begin
            int waited;
            waited = 0;
            for (int k = 0; k < 20; k++) begin
                if (n_abort == 0) begin
                    tick();
                    waited++;
                end
            end
            chk("t4_abort_delay", 32'(waited), 32'd9);
        end
        chk("t4_pad_grant", 32'(grant), 32'd0);
        chk("t4_pad_data", 32'(data_out), 32'(PADB));
        tick();
        chk("t4_pad2_valid", 32'(valid_out), 32'd1);
        chk("t4_pad2_last", 32'(word_last), 32'd1);
        chk("t4_pad2_abort", 32'(abort), 32'd0);

        // 5: short stall then resume, no abort
        do_reset();
        base[2] = 8'h20; drive();
        req = 4'b0100; valid_in = 4'b0100;
        tick(); tick();
        valid_in = 4'b0000;
        tick(); tick(); tick();
        valid_in = 4'b0100;
        tick(); tick(); tick();
        valid_in = 4'b0000;
        tick();
        chk("t5_nbytes", 32'(obs_bytes.size()), 32'd4);
        chk("t5_noabort", 32'(n_abort), 32'd0);
        chk("t5_last", 32'(obs_last[3]), 32'd1);
        chk("t5_byte3", 32'(obs_bytes[3]), 32'h23);

        // 6: req[1] rises as word from 0 completes
        do_reset();
        for (int i = 0; i < 4; i++) base[i] = 8'(i * 16);
        drive();
        req = 4'b0101; valid_in = 4'b0101;
        tick(); tick(); tick(); tick();
        req = 4'b0111; valid_in = 4'b0111;
        for (int k = 0; k < 13; k++) tick();
        chk("t6_g0", 32'(obs_wg[0]), 32'h1);
        chk("t6_g1", 32'(obs_wg[1]), 32'h2);
        chk("t6_g2", 32'(obs_wg[2]), 32'h4);
        chk("t6_g3", 32'(obs_wg[3]), 32'h1);

        // randomized traffic against the model
        do_reset();
        rnd = 1;
        begin
            int stall;
            stall = 0;
            req = 4'($urandom);
            for (int k = 0; k < 1500; k++) begin
                if ($urandom_range(7) == 0) req = 4'($urandom);
                if (stall > 0) begin
                    valid_in = 4'd0;
                    stall--;
                end else begin
                    valid_in = 4'($urandom) | 4'($urandom);
                    if ($urandom_range(25) == 0)
                        stall = $urandom_range(14, 3);
                end
                data_in = $urandom;
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/m8b_32b_arb.md
Name: m8b_32b_arb

Overview:
- Round-robin arbiter that shares the 8-bit input of the m8b_32b converter among four byte-stream requesters.
- Grants are word-granular: each grant delivers exactly 4 valid bytes, so every 32-bit word the converter assembles comes from one source.
- If the granted source stalls too long, the block pads the word so converter alignment is never lost.
- Runs entirely in the clk_4f domain, directly in front of m8b_32b.

Parameters:
- N_REQ, 4, number of requesters (fixed at 4 for this revision).
- TIMEOUT, 8, consecutive granted cycles without a valid byte before a pad abort; legal range is 1 to 255.
- PAD_BYTE, 8'h00, byte value emitted when padding an aborted word.

Ports:
- clk_4f  input  1  byte clock, the same clock that drives m8b_32b clk_4f.
- reset_L  input  1  asynchronous, active-low reset.
- req  input  4  per-requester request; level-sensitive; must stay high while that requester has bytes pending.
- valid_in  input  4  per-requester byte valid; only the granted bit is honoured.
- data_in  input  32  requester bytes; requester i uses data_in[8i+7:8i].
- data_out  output  8  byte to m8b_32b data_in.
- valid_out  output  1  byte valid to m8b_32b valid_in.
- grant  output  4  one-hot grant, or 0 when no grant is active.
- word_first  output  1  high with valid_out on byte 0 of a word.
- word_last  output  1  high with valid_out on byte 3 of a word.
- abort  output  1  one-cycle pulse, coincident with the first pad byte.

Behaviour:
- Reset (reset_L low, asynchronous):
  - data_out=0, valid_out=0, grant=0, word_first=0, word_last=0, abort=0.
  - state=IDLE, byte_cnt=0, idle_cnt=0, rr_ptr=0.
  - Release is sampled on the next clk_4f rising edge.
  - Reset asserted mid-word discards the partial word with no padding; the downstream converter is reset by the same reset_L.
- All outputs are registered.
- IDLE:
  - grant=0, valid_out=0.
  - If req!=0, select the first set bit searching from rr_ptr upward with wrap (3 wraps to 0).
  - grant is asserted on the next edge; go to XFER.
- XFER (granted requester g):
  - Each cycle valid_in[g]=1: data_out<=data_in[g], valid_out<=1, byte_cnt++, idle_cnt<=0. Data latency is 1 cycle from the sampled valid_in to valid_out.
  - word_first=1 when byte_cnt was 0; word_last=1 when byte_cnt was 3.
  - Each cycle valid_in[g]=0: valid_out<=0, idle_cnt++.
  - grant is held regardless of valid_in; req[g] is ignored until the word completes, so dropping req mid-word does not release the grant.
  - On the 4th byte: rr_ptr<=g+1 (mod 4), byte_cnt<=0, then re-arbitrate in the same cycle with search starting at g+1.
    - If any req is set, the new grant takes effect on the next edge with no bubble; a lone requester is re-granted back-to-back.
    - Otherwise go to IDLE.
  - When idle_cnt reaches TIMEOUT with byte_cnt!=0: go to PAD.
  - When idle_cnt reaches TIMEOUT with byte_cnt==0: drop the grant, rr_ptr<=g+1, go to IDLE; no bytes emitted, no abort.
- PAD:
  - grant=0.
  - Each cycle emit data_out=PAD_BYTE, valid_out=1, byte_cnt++.
  - abort=1 on the first pad byte only; word_last=1 on byte 3.
  - After byte 3: rr_ptr<=g+1, re-arbitrate exactly as in XFER.
- A valid_in[g] arriving in the same cycle idle_cnt hits TIMEOUT wins: the byte is accepted and no abort occurs.
- Bytes on ungranted valid_in bits are ignored and never forwarded.
- Invariant: between any two word_last pulses, exactly 4 valid_out cycles occur.
- Counters: byte_cnt is 2 bits and wraps 3->0 only at word completion; idle_cnt is 8 bits and saturates.

Test Plan:
1. Reset mid-XFER (2 bytes sent) -> outputs 0 asynchronously; after release with req=0001, word starts fresh: word_first on first byte, 4 valid_out cycles.
2. req=0001, valid_in[0]=1 continuously, data_in[7:0]=A0,A1,A2,A3 -> grant=0001 one edge after req; data_out A0..A3 on 4 consecutive cycles with word_first/word_last on A0/A3; re-granted to 0001 with no idle cycle.
3. req=1111, all sources streaming (source i sends 8'hi0..i3) -> grant sequence 0001,0010,0100,1000,0001, each held exactly 4 valid_out cycles, 16 bytes contiguous with no bubbles.
4. req=0010, requester 1 sends 2 bytes then valid_in low for 8 cycles -> after 8 idle cycles abort pulses; data_out=00,00 with valid_out=1 and word_last on the second pad byte; grant=0 during pad.
5. Requester 2 gets grant, sends 1 byte, stalls 3 cycles, then resumes 3 bytes -> no abort; 4 valid bytes total with valid_out gaps; word_last on the 4th byte.
6. req=0101, rr_ptr=0: word from 0 completes while req[1] rises in the same cycle -> next grant=0010 (search starts at 1), then 0100, then 0001.
